addr_byte_to_word: RTL and testbench
====================================

// Module: addr_byte_to_word
// PURPOSE
//  Inverse of the address-calc word->byte shifter: converts a byte address into
//  a word index (right shift by SHIFT) with alignment check. Sits at the router's
//  address ingress; valid/ready handshake on both sides, one register stage plus
//  skid buffer for full throughput under backpressure. Counts misaligned requests.
// PARAMETERS
//  WIDTH      32  address / word-index width in bits
//  SHIFT      2   right-shift amount (log2 of bytes per word), 1..WIDTH-1
//  ARITH      1   1: arithmetic shift (sign-extend MSB); 0: logical (zero-fill)
//  ERR_CNT_W  8   width of saturating misalignment counter
// PORTS
//  clk             in   1          clock, all state on rising edge
//  rst_n           in   1          asynchronous active-low reset
//  in_valid        in   1          byte address valid
//  in_ready        out  1          block can accept in_addr this cycle
//  in_addr         in   WIDTH      byte address
//  out_valid       out  1          word result valid
//  out_ready       in   1          downstream accepts result this cycle
//  out_word        out  WIDTH      in_addr >> SHIFT (per ARITH)
//  out_offset      out  SHIFT      in_addr[SHIFT-1:0]
//  out_misaligned  out  1          out_offset != 0
//  err_clear       in   1          synchronous clear of err_count
//  err_count       out  ERR_CNT_W  saturating count of accepted misaligned inputs
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, in_ready=1, out_word=0,
//    out_offset=0, out_misaligned=0, err_count=0, state=EMPTY.
//  - Transfer on a side occurs when valid && ready at a rising edge.
//  - Latency: accepted input appears on outputs next cycle (1 cycle) when empty.
//  - State machine (main reg M, skid reg S):
//    EMPTY: in_ready=1, out_valid=0. Accept -> load M, go ONE.
//    ONE:   in_ready=1, out_valid=1. Accept&&out xfer -> reload M, stay ONE;
//           accept&&!out xfer -> load S, go TWO; !accept&&out xfer -> EMPTY.
//    TWO:   in_ready=0, out_valid=1. Out xfer -> M<=S, go ONE.
//  - in_ready is a register output (no comb path from out_ready to in_ready).
//  - Outputs held stable while out_valid && !out_ready.
//  - Order preserved; no drop, no duplicate. Max 2 entries in flight.
//  - Arithmetic: out_word = ARITH ? {{SHIFT{in_addr[WIDTH-1]}}, in_addr[WIDTH-1:SHIFT]}
//    : {{SHIFT{1'b0}}, in_addr[WIDTH-1:SHIFT]}. Low bits truncated, not rounded.
//  - Misaligned inputs still pass through (flagged, not blocked).
//  - err_count: +1 on each accepted input with nonzero offset, saturates at
//    all-ones (no wrap). err_clear with simultaneous misaligned accept -> 1;
//    err_clear alone -> 0. Counted at acceptance, independent of output side.
//  - Reset mid-operation: all in-flight entries discarded, counter cleared.
//  - in_addr ignored when in_valid=0; out_ready ignored when out_valid=0.
// TESTING
//  1 in_addr=0x0000_0010, out_ready=1 -> next cycle out_word=0x4, offset=0,
//    misaligned=0, err_count=0.
//  2 in_addr=0xFFFF_FFF0: ARITH=1 -> out_word=0xFFFF_FFFC; ARITH=0 ->
//    out_word=0x3FFF_FFFC.
//  3 in_addr=0x0000_0013 -> out_word=0x4, offset=3, misaligned=1, err_count=1.
//  4 out_ready=0 for 3 cycles, in_valid=1 with 0x10,0x20,0x30 -> first two
//    accepted, in_ready=0 on third; release -> outputs 0x4,0x8,0xC in order.
//  5 300 misaligned accepts -> err_count=255 held; err_clear with misaligned
//    accept same cycle -> 1.
//  6 rst_n low while in TWO -> out_valid=0, in_ready=1, err_count=0 immediately;
//    no stale output after release.

Source files
------------

// File: rtl/addr_byte_to_word.sv
// Byte address to word index converter with alignment flag, registered output
// stage plus skid entry, and a saturating misalignment counter.
module addr_byte_to_word #(
  parameter int WIDTH     = 32,
  parameter int SHIFT     = 2,
  parameter int ARITH     = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_word,
  output logic [SHIFT-1:0]     out_offset,
  output logic                 out_misaligned,
  input  logic                 err_clear,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state
);

  // Handshake: a side transfers on a rising edge where valid && ready. in_ready
  // and out_valid decode only the state register, so no comb path crosses the
  // block; an offered result stays stable until out_ready takes it.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic             in_xfer;
  logic             out_xfer;
  logic             load_m_in;
  logic             load_m_skid;
  logic             load_s;

  logic             fill;
  logic [WIDTH-1:0] conv_word;
  logic [SHIFT-1:0] conv_off;
  logic             conv_mis;

  logic [WIDTH-1:0] m_word;
  logic [SHIFT-1:0] m_off;
  logic             m_mis;
  logic [WIDTH-1:0] s_word;
  logic [SHIFT-1:0] s_off;
  logic             s_mis;

  // Conversion of the incoming address; low bits are truncated, not rounded.
  always_comb begin
    fill      = (ARITH != 0) ? in_addr[WIDTH-1] : 1'b0;
    conv_word = {{SHIFT{fill}}, in_addr[WIDTH-1:SHIFT]};
    conv_off  = in_addr[SHIFT-1:0];
    conv_mis  = |in_addr[SHIFT-1:0];
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and load selection
  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          load_m_in = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_m_in = 1'b1;
        end else if (in_xfer) begin
          load_s  = 1'b1;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          load_m_skid = 1'b1;
          state_d     = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_word <= '0;
      m_off  <= '0;
      m_mis  <= 1'b0;
      s_word <= '0;
      s_off  <= '0;
      s_mis  <= 1'b0;
    end else begin
      if (load_m_in) begin
        m_word <= conv_word;
        m_off  <= conv_off;
        m_mis  <= conv_mis;
      end else if (load_m_skid) begin
        m_word <= s_word;
        m_off  <= s_off;
        m_mis  <= s_mis;
      end
      if (load_s) begin
        s_word <= conv_word;
        s_off  <= conv_off;
        s_mis  <= conv_mis;
      end
    end
  end

  // Counted at acceptance; a clear coinciding with a misaligned accept leaves 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= (in_xfer && conv_mis) ? ERR_CNT_W'(1) : '0;
    end else if (in_xfer && conv_mis && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign out_word       = m_word;
  assign out_offset     = m_off;
  assign out_misaligned = m_mis;
  assign state          = state_q;

endmodule

// File: tb/tb_addr_byte_to_word.sv
// Bench for addr_byte_to_word: arithmetic and logical instances share stimulus;
// a scoreboard queue holds expected results from acceptance until output.
module tb_addr_byte_to_word;

  localparam int WIDTH     = 32;
  localparam int SHIFT     = 2;
  localparam int ERR_CNT_W = 8;
  localparam int EW        = 2 * WIDTH + SHIFT + 1;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_addr;
  logic                 out_ready;
  logic                 err_clear;

  logic                 in_ready,  in_ready_l;
  logic                 out_valid, out_valid_l;
  logic [WIDTH-1:0]     out_word,  out_word_l;
  logic [SHIFT-1:0]     out_offset, out_offset_l;
  logic                 out_mis,   out_mis_l;
  logic [ERR_CNT_W-1:0] err_count, err_count_l;
  logic [1:0]           state,     state_l;

  logic [EW-1:0]        exp_q[$];
  logic [ERR_CNT_W-1:0] exp_err;
  int                   checks;
  int                   errors;

  addr_byte_to_word #(.WIDTH(WIDTH), .SHIFT(SHIFT), .ARITH(1), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_offset(out_offset), .out_misaligned(out_mis),
    .err_clear(err_clear), .err_count(err_count), .state(state)
  );

  addr_byte_to_word #(.WIDTH(WIDTH), .SHIFT(SHIFT), .ARITH(0), .ERR_CNT_W(ERR_CNT_W)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_addr(in_addr), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_word(out_word_l), .out_offset(out_offset_l), .out_misaligned(out_mis_l),
    .err_clear(err_clear), .err_count(err_count_l), .state(state_l)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid with addr until accepted; leaves in_valid asserted.
  task automatic push_addr(input logic [WIDTH-1:0] addr);
    int n;
    in_valid = 1'b1;
    in_addr  = addr;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("accept_timeout", in_ready, 1);
    step();
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Scoreboard: sampled on the falling edge, ahead of the next rising edge
  always @(negedge clk) begin
    logic [EW-1:0]          e;
    logic signed [WIDTH-1:0] sa;
    logic [WIDTH-1:0]        wl;
    logic                    mis;
    if (!rst_n) begin
      exp_q.delete();
      exp_err = '0;
    end else begin
      check("in_ready",    in_ready,    exp_q.size() < 2);
      check("in_ready_l",  in_ready_l,  exp_q.size() < 2);
      check("out_valid",   out_valid,   exp_q.size() > 0);
      check("out_valid_l", out_valid_l, exp_q.size() > 0);
      check("err_count",   err_count,   exp_err);
      check("err_count_l", err_count_l, exp_err);
      if (out_valid) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("out_word",   out_word,   e[EW-1 -: WIDTH]);
          check("out_word_l", out_word_l, e[WIDTH+SHIFT : SHIFT+1]);
          check("out_offset", out_offset, e[SHIFT:1]);
          check("out_mis",    out_mis,    e[0]);
          check("out_mis_l",  out_mis_l,  e[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      mis = (in_addr[SHIFT-1:0] != '0);
      if (in_valid && in_ready) begin
        sa = in_addr;
        sa = sa >>> SHIFT;
        wl = in_addr >> SHIFT;
        exp_q.push_back({sa, wl, in_addr[SHIFT-1:0], mis});
      end
      if (err_clear) begin
        exp_err = (in_valid && in_ready && mis) ? ERR_CNT_W'(1) : '0;
      end else if (in_valid && in_ready && mis && exp_err != {ERR_CNT_W{1'b1}}) begin
        exp_err = exp_err + ERR_CNT_W'(1);
      end
    end
  end

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    exp_err   = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    out_ready = 1'b1;
    err_clear = 1'b0;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_word",  out_word, 0);
    check("rst_offset",    out_offset, 0);
    check("rst_mis",       out_mis, 0);
    check("rst_err",       err_count, 0);
    check("rst_state",     state, 0);
    rst_n = 1'b1;
    step();

    // Aligned, sign-extending, and misaligned conversions
    push_addr(32'h0000_0010);
    in_valid = 1'b0;
    check("t1_word", out_word, 32'h4);
    check("t1_off",  out_offset, 0);
    push_addr(32'hFFFF_FFF0);
    in_valid = 1'b0;
    check("t2_word_arith", out_word, 32'hFFFF_FFFC);
    check("t2_word_logic", out_word_l, 32'h3FFF_FFFC);
    push_addr(32'h0000_0013);
    in_valid = 1'b0;
    check("t3_word", out_word, 32'h4);
    check("t3_off",  out_offset, 3);
    check("t3_mis",  out_mis, 1);
    step();
    check("t3_err",  err_count, 1);
    idle(3);

    // Backpressure fills main and skid entries
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_addr   = 32'h10;
    step();
    in_addr   = 32'h20;
    step();
    in_addr   = 32'h30;
    check("t4_in_ready_full", in_ready, 0);
    check("t4_state_two", state, 2);
    step();
    step();
    check("t4_hold_word", out_word, 32'h4);
    out_ready = 1'b1;
    push_addr(32'h30);
    idle(4);

    // Counter saturation and clear interactions
    for (int i = 0; i < 300; i++)
      push_addr(($urandom() & 32'hFFFF_FFFC) | WIDTH'($urandom_range(1, 3)));
    in_valid = 1'b0;
    step();
    check("t5_saturated", err_count, 8'hFF);
    err_clear = 1'b1;
    push_addr(32'h0000_0013);
    err_clear = 1'b0;
    in_valid  = 1'b0;
    check("t5_clear_with_mis", err_count, 1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("t5_clear_alone", err_count, 0);
    idle(3);

    // Reset while both entries are occupied
    out_ready = 1'b0;
    push_addr(32'h41);
    push_addr(32'h50);
    in_valid = 1'b0;
    check("t6_state_two", state, 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_in_ready",  in_ready, 1);
    check("t6_rst_err",       err_count, 0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_addr   = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      err_clear = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid  = 1'b0;
    err_clear = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    step();
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
